// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: widths, FSM encodings and
// the sign-magnitude helper used when latching operands.
// Imported by div_unit_if, div_step and div_unit.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Magnitude of a WIDTH-bit operand, one bit wider so that the most
  // negative value still has a positive representation.
  function automatic logic [DIV_WIDTH:0] abs_mag(input logic [DIV_WIDTH-1:0] v,
                                                 input logic neg);
    if (neg) begin
      return {1'b0, ~v} + (DIV_WIDTH+1)'(1);
    end
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the pipeline and the divider.
// master: drives div_start/div_signed/x/y/div_cancel, receives status/results.
// slave : the divider side.
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             div_cancel;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output div_start, div_signed, x, y, div_cancel,
    input  div_busy, div_done, quotient, remainder
  );

  modport slave (
    input  div_start, div_signed, x, y, div_cancel,
    output div_busy, div_done, quotient, remainder
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
// Latency: 0 cycles. Backpressure: none.
// Ports: rem_in/divisor magnitudes and next dividend bit in; rem_out, q_bit out.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0] rem_in,
  input  logic           dvd_bit,
  input  logic [WIDTH:0] divisor,
  output logic [WIDTH:0] rem_out,
  output logic           q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {rem_in, dvd_bit};
  assign diff    = shifted - {1'b0, divisor};

  // Partial remainder stays below 2^WIDTH, so the extra top bit of diff is a
  // reliable borrow: clear means the trial subtraction succeeded.
  assign q_bit   = ~diff[WIDTH+1];
  assign rem_out = (WIDTH+1)'(q_bit ? diff : shifted);

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider, one quotient bit per cycle.
// Latency: start at edge 0 -> CALC cycles 1..WIDTH, FIX WIDTH+1, div_done WIDTH+2.
// Backpressure: none; div_start outside IDLE is dropped, div_cancel aborts.
// Ports: clk, resetn (async, active-low), bus (div_unit_if.slave).
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus
);

  div_state_e       state;
  div_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   rem;       // partial remainder magnitude
  logic [WIDTH:0]   dvsr;      // divisor magnitude
  logic [WIDTH-1:0] dvd;       // dividend shifts out MSB-first, quotient shifts in
  logic             sx;
  logic             sy;
  logic             sgn;
  logic             zero_dvsr;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic [WIDTH:0]   rem_nxt;
  logic             q_bit;
  logic [WIDTH:0]   mag_x;
  logic [WIDTH:0]   mag_y;
  logic             busy;
  logic             done;
  logic             last_iter;
  logic             q_neg;
  logic             r_neg;

  assign mag_x     = abs_mag(bus.x, bus.div_signed & bus.x[WIDTH-1]);
  assign mag_y     = abs_mag(bus.y, bus.div_signed & bus.y[WIDTH-1]);
  assign last_iter = (cnt == CNT_W'(WIDTH-1));

  // A zero divisor yields all-ones regardless of signs, so skip negation.
  assign q_neg = sgn & (sx ^ sy) & ~zero_dvsr;
  assign r_neg = sgn & sx;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (dvsr),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.div_start && !bus.div_cancel) begin
          state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        if (bus.div_cancel) begin
          state_nxt = ST_IDLE;
        end else if (last_iter) begin
          state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        busy      = 1'b1;
        state_nxt = bus.div_cancel ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt         <= '0;
      rem         <= '0;
      dvsr        <= '0;
      dvd         <= '0;
      sx          <= 1'b0;
      sy          <= 1'b0;
      sgn         <= 1'b0;
      zero_dvsr   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.div_start && !bus.div_cancel) begin
            cnt       <= '0;
            rem       <= '0;
            dvd       <= WIDTH'(mag_x);
            dvsr      <= mag_y;
            sx        <= bus.x[WIDTH-1];
            sy        <= bus.y[WIDTH-1];
            sgn       <= bus.div_signed;
            zero_dvsr <= (bus.y == '0);
          end
        end
        ST_CALC: begin
          if (!bus.div_cancel) begin
            rem <= rem_nxt;
            dvd <= {dvd[WIDTH-2:0], q_bit};
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (!bus.div_cancel) begin
            if (zero_dvsr) begin
              quotient_q <= '1;
            end else begin
              quotient_q <= q_neg ? -dvd : dvd;
            end
            // With a zero divisor rem has collected |x|, so the remainder
            // sign rule reproduces x exactly.
            remainder_q <= r_neg ? WIDTH'(-rem) : WIDTH'(rem);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.div_busy  = busy;
  assign bus.div_done  = done;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits; only 32 is required to be supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port div_start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port div_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with div_start.
REQ-006 SHALL have port x  input  WIDTH  dividend; sampled with div_start.
REQ-007 SHALL have port y  input  WIDTH  divisor; sampled with div_start.
REQ-008 SHALL have port div_cancel  input  1  pipeline flush; aborts any division in progress.
REQ-009 SHALL have port div_busy  output  1  high while a division is in CALC or FIX.
REQ-010 SHALL have port div_done  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port quotient  output  WIDTH  registered quotient (to LO).
REQ-012 SHALL have port remainder  output  WIDTH  registered remainder (to HI).

Function
REQ-013 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-014 IDLE with div_start=1 and div_cancel=0 SHALL latch the operand magnitudes, the signs, div_signed and a zero-divisor flag, clear the iteration counter, and move to CALC.
REQ-015 CALC SHALL produce one quotient bit per cycle by restoring division on the magnitudes (shift partial remainder left 1, trial-subtract |y|, keep the result if it is non-negative), MSB first, for exactly WIDTH cycles.
REQ-016 When the counter reaches WIDTH-1, CALC SHALL go to FIX.
REQ-017 FIX SHALL apply signs and register quotient and remainder: quotient sign = sign(x) XOR sign(y), remainder sign = sign(x), signs applied only when div_signed=1; results SHALL truncate toward zero.
REQ-018 DONE SHALL assert div_done for exactly one cycle and then return to IDLE.
REQ-019 Latency: with div_start sampled at edge 0, CALC SHALL occupy cycles 1..32, FIX cycle 33 and DONE cycle 34; div_done SHALL be high only in cycle 34.
REQ-020 div_busy SHALL be high in CALC and FIX only and low in IDLE and DONE.
REQ-021 quotient and remainder SHALL hold their last values until the next FIX, including across cancel.
REQ-022 div_start outside IDLE SHALL be ignored; there is no queueing.
REQ-023 div_cancel SHALL force IDLE at the next edge from any state, without asserting div_done and without updating the results.
REQ-024 div_cancel together with div_start in IDLE SHALL win: the state stays IDLE.
REQ-025 Divide by zero SHALL take normal latency and return quotient = all ones and remainder = x, regardless of div_signed.
REQ-026 Signed 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0, with no trap.
REQ-027 Magnitude datapath SHALL be WIDTH+1 bits so that |0x80000000| is representable.

Reset
REQ-028 resetn low SHALL asynchronously force state IDLE, counter 0, div_busy 0, div_done 0, quotient 0 and remainder 0.
REQ-029 Reset asserted mid-division SHALL discard the operation; the first division after release SHALL behave as from power-up.

Structure
REQ-030 State encodings (2 bits), WIDTH and the counter width SHALL live in the shared CPU defines header.
REQ-031 A single combinational sub-module div_step (one shift/trial-subtract iteration: partial remainder and divisor in, next partial remainder and quotient bit out) SHALL be instantiated once in div_unit.

Verification
REQ-032 Unsigned 100 / 7 -> quotient 14, remainder 2; div_done exactly 34 cycles after div_start; div_busy high in cycles 1..33.
REQ-033 Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned same operands -> quotient 0x7FFFFFFC, remainder 1.
REQ-034 Divide by zero, x = 0x12345678, both modes -> quotient 0xFFFFFFFF, remainder 0x12345678, latency 34.
REQ-035 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-036 div_cancel at cycle 10 of a division -> IDLE next cycle, no div_done, prior results unchanged; a new div_start then yields a correct result.
REQ-037 div_start pulsed at cycle 5 during a division, and resetn pulsed low at cycle 20 of another -> extra start ignored (single div_done); reset clears all outputs immediately.
